gate_ctrl_multi: RTL and testbench

Parametrised automatic gate controller: N presence sensors, symmetric travel timing with a position counter, a retriggerable hold-open timer, and obstruction reversal while closing. It drives the same green/blue/red status LEDs as the existing single-sensor gate block. It is the drop-in replacement for multi-entrance gates in the door subsystem, with LED meaning unchanged.

---
 rtl/gate_ctrl_multi_if.sv | 38 +++
 rtl/gate_ctrl_multi.sv | 131 +++++++++++++
 tb/tb_gate_ctrl_multi.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/gate_ctrl_multi_if.sv
// Signal bundle between a gate controller and its environment.
// The lock line exists only when GATE_LOCK_EN is defined.
interface gate_ctrl_multi_if #(
    parameter int NUM_SENSORS   = 4,
    parameter int TRAVEL_CYCLES = 10
);
    localparam int PW = $clog2(TRAVEL_CYCLES + 1);

    logic [NUM_SENSORS-1:0] sensor;
`ifdef GATE_LOCK_EN
    logic                   lock;
`endif
    logic                   green_led;
    logic                   blue_led;
    logic                   red_led;
    logic                   gate_closed;
    logic [PW-1:0]          position;

`ifdef GATE_LOCK_EN
    modport master (
        output sensor, lock,
        input  green_led, blue_led, red_led, gate_closed, position
    );
    modport slave (
        input  sensor, lock,
        output green_led, blue_led, red_led, gate_closed, position
    );
`else
    modport master (
        output sensor,
        input  green_led, blue_led, red_led, gate_closed, position
    );
    modport slave (
        input  sensor,
        output green_led, blue_led, red_led, gate_closed, position
    );
`endif
endinterface

// File: rtl/gate_ctrl_multi.sv
// Multi-sensor automatic gate controller with position counter,
// retriggerable hold-open timer and reversal on obstruction while closing.
// Optional feature macro: GATE_LOCK_EN (adds a force-closed lock input).
//
// state   | meaning
// --------+------------------------------------------------------
// CLOSED  | gate shut, pos = 0, waiting for presence
// OPENING | travelling open, pos counts up, sensors ignored
// OPEN    | fully open, hold timer counts down, reloaded by presence
// CLOSING | travelling shut, pos counts down, presence reverses
module gate_ctrl_multi #(
    parameter int NUM_SENSORS   = 4,
    parameter int TRAVEL_CYCLES = 10,
    parameter int HOLD_CYCLES   = 20
) (
    input logic               clk,
    input logic               reset,
    gate_ctrl_multi_if.slave  gif
);
    localparam int PW = $clog2(TRAVEL_CYCLES + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [PW-1:0] POS_MAX  = PW'(TRAVEL_CYCLES);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);

    typedef enum logic [1:0] {
        CLOSED  = 2'd0,
        OPENING = 2'd1,
        OPEN    = 2'd2,
        CLOSING = 2'd3
    } state_t;

    state_t                 state;
    logic [PW-1:0]          pos;
    logic [HW-1:0]          hold;
    logic [NUM_SENSORS-1:0] sens_s1;
    logic [NUM_SENSORS-1:0] sens_s2;
    logic                   active;
    logic                   lk;

    // Two-flop synchronizer per raw sensor bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sens_s1 <= '0;
            sens_s2 <= '0;
        end else begin
            sens_s1 <= gif.sensor;
            sens_s2 <= sens_s1;
        end
    end

    assign active = |sens_s2;

`ifdef GATE_LOCK_EN
    logic lock_s1;
    logic lock_s2;

    // Two-flop synchronizer for the lock request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_s1 <= 1'b0;
            lock_s2 <= 1'b0;
        end else begin
            lock_s1 <= gif.lock;
            lock_s2 <= lock_s1;
        end
    end

    assign lk = lock_s2;
`else
    assign lk = 1'b0;
`endif

    // Gate sequencing FSM with travel position and hold timer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= CLOSED;
            pos   <= '0;
            hold  <= '0;
        end else begin
            case (state)
                CLOSED: begin
                    pos <= '0;
                    if (active && !lk)
                        state <= OPENING;
                end
                OPENING: begin
                    if (lk) begin
                        state <= CLOSING;
                    end else if (pos == POS_MAX) begin
                        state <= OPEN;
                        hold  <= HOLD_MAX;
                    end else begin
                        pos <= pos + 1'b1;
                    end
                end
                OPEN: begin
                    if (lk)
                        state <= CLOSING;
                    else if (active)
                        hold <= HOLD_MAX;
                    else if (hold == '0)
                        state <= CLOSING;
                    else
                        hold <= hold - 1'b1;
                end
                CLOSING: begin
                    // Reversal keeps pos so reopening covers only the distance closed.
                    if (active && !lk)
                        state <= OPENING;
                    else if (pos == '0)
                        state <= CLOSED;
                    else
                        pos <= pos - 1'b1;
                end
                default: begin
                    state <= CLOSED;
                    pos   <= '0;
                    hold  <= '0;
                end
            endcase
        end
    end

    // Status outputs decoded purely from registered state.
    assign gif.green_led   = (state == OPENING);
    assign gif.blue_led    = (state == OPEN);
    assign gif.red_led     = (state == CLOSING);
    assign gif.gate_closed = (state == CLOSED);
    assign gif.position    = pos;

endmodule

// File: tb/tb_gate_ctrl_multi.sv
// Scoreboard bench for gate_ctrl_multi: stimulus pushes time-stamped
// expected output snapshots, a monitor pops one per observed output change.
module tb_gate_ctrl_multi;
    localparam int N  = 4;
    localparam int T  = 10;
    localparam int H  = 20;
    localparam int PW = $clog2(T + 1);
    localparam int OW = 4 + PW;

    localparam logic [3:0] S_OPENING = 4'b1000;
    localparam logic [3:0] S_OPEN    = 4'b0100;
    localparam logic [3:0] S_CLOSING = 4'b0010;
    localparam logic [3:0] S_CLOSED  = 4'b0001;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    // Edge counter used to time-stamp expected events.
    always @(posedge clk) cyc <= cyc + 1;

    gate_ctrl_multi_if #(.NUM_SENSORS(N), .TRAVEL_CYCLES(T)) gif ();

    gate_ctrl_multi #(
        .NUM_SENSORS(N),
        .TRAVEL_CYCLES(T),
        .HOLD_CYCLES(H)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .gif  (gif)
    );

    typedef struct {
        int              cyc;
        logic [OW-1:0]   obs;
    } exp_t;

    exp_t q[$];

    function automatic logic [OW-1:0] obs_now();
        return {gif.green_led, gif.blue_led, gif.red_led, gif.gate_closed, gif.position};
    endfunction

    task automatic push(input int c, input logic [3:0] s, input int p);
        exp_t e;
        e.cyc = c;
        e.obs = {s, PW'(p)};
        q.push_back(e);
    endtask

    task automatic exp_open(input int c);
        for (int k = 0; k <= T; k++) push(c + k, S_OPENING, k);
        push(c + T + 1, S_OPEN, T);
    endtask

    task automatic exp_close(input int c);
        for (int k = 0; k <= T; k++) push(c + k, S_CLOSING, T - k);
        push(c + T + 1, S_CLOSED, 0);
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic drain(input string name);
        int g = 0;
        while (q.size() != 0 && g < 300) begin
            @(negedge clk);
            g++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_%s: %0d expected events still pending, required 0", name, q.size());
            q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    // Monitor: every change of the output snapshot is one scoreboard check.
    initial begin
        logic [OW-1:0] prev;
        logic [OW-1:0] cur;
        exp_t          e;
        prev = {S_CLOSED, PW'(0)};
        forever begin
            @(negedge clk);
            cur = obs_now();
            if (cur !== prev) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change: got obs=%b at cyc %0d, required no change", cur, cyc);
                end else begin
                    e = q.pop_front();
                    if (cur !== e.obs || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL event: got obs=%b at cyc %0d, required obs=%b at cyc %0d",
                                 cur, cyc, e.obs, e.cyc);
                    end
                end
                prev = cur;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int n2;
        gif.sensor = '0;
`ifdef GATE_LOCK_EN
        gif.lock = 1'b0;
`endif
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (obs_now() !== {S_CLOSED, PW'(0)}) begin
            errors++;
            $display("FAIL reset_state: got %b, required %b", obs_now(), {S_CLOSED, PW'(0)});
        end
        reset = 1'b0;
        @(negedge clk);

        // Defaults: 5-cycle pulse, full open / hold / close.
        n = cyc;
        exp_open(n + 3);
        exp_close(n + 35);
        gif.sensor[2] = 1'b1;
        wait_to(n + 5);
        gif.sensor[2] = 1'b0;
        drain("defaults");

        // Retrigger while open at hold=5.
        n = cyc;
        exp_open(n + 3);
        exp_close(n + 55);
        gif.sensor[0] = 1'b1;
        wait_to(n + 3);
        gif.sensor[0] = 1'b0;
        wait_to(n + 29);
        gif.sensor[0] = 1'b1;
        wait_to(n + 32);
        gif.sensor[0] = 1'b0;
        drain("retrigger");

        // Reversal at position 4 while closing.
        n = cyc;
        exp_open(n + 3);
        for (int k = 0; k <= 6; k++) push(n + 35 + k, S_CLOSING, 10 - k);
        for (int k = 0; k <= 6; k++) push(n + 42 + k, S_OPENING, 4 + k);
        push(n + 49, S_OPEN, 10);
        exp_close(n + 70);
        gif.sensor[2] = 1'b1;
        wait_to(n + 5);
        gif.sensor[2] = 1'b0;
        wait_to(n + 39);
        gif.sensor[3] = 1'b1;
        wait_to(n + 41);
        gif.sensor[3] = 1'b0;
        drain("reversal");

        // Async reset mid-opening at position 6, then normal reopen.
        n = cyc;
        for (int k = 0; k <= 6; k++) push(n + 3 + k, S_OPENING, k);
        push(n + 10, S_CLOSED, 0);
        gif.sensor[1] = 1'b1;
        wait_to(n + 5);
        gif.sensor[1] = 1'b0;
        wait_to(n + 9);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (obs_now() !== {S_CLOSED, PW'(0)}) begin
            errors++;
            $display("FAIL async_reset: got %b, required %b", obs_now(), {S_CLOSED, PW'(0)});
        end
        wait_to(n + 11);
        reset = 1'b0;
        @(negedge clk);
        n2 = cyc;
        exp_open(n2 + 3);
        exp_close(n2 + 35);
        gif.sensor[1] = 1'b1;
        wait_to(n2 + 5);
        gif.sensor[1] = 1'b0;
        drain("after_reset");

        // Overlapping sensors staggered by 7 cycles during OPEN.
        n = cyc;
        exp_open(n + 3);
        exp_close(n + 50);
        gif.sensor[0] = 1'b1;
        wait_to(n + 16);
        gif.sensor[1] = 1'b1;
        wait_to(n + 20);
        gif.sensor[0] = 1'b0;
        wait_to(n + 27);
        gif.sensor[1] = 1'b0;
        drain("overlap");

`ifdef GATE_LOCK_EN
        // Lock while open with sensor held: close fully, stay closed, reopen on release.
        n = cyc;
        exp_open(n + 3);
        exp_close(n + 23);
        exp_open(n + 43);
        exp_close(n + 75);
        gif.sensor[0] = 1'b1;
        wait_to(n + 20);
        gif.lock = 1'b1;
        wait_to(n + 40);
        gif.lock = 1'b0;
        wait_to(n + 45);
        gif.sensor[0] = 1'b0;
        drain("lock");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
